// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Opcode encodings, opcode width and FSM state type for alu_seq.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] c_OP_ADD  = 5'b00000;
  localparam logic [OP_W-1:0] c_OP_SUB  = 5'b00001;
  localparam logic [OP_W-1:0] c_OP_AND  = 5'b00010;
  localparam logic [OP_W-1:0] c_OP_OR   = 5'b00011;
  localparam logic [OP_W-1:0] c_OP_XOR  = 5'b00100;
  localparam logic [OP_W-1:0] c_OP_NOR  = 5'b00101;
  localparam logic [OP_W-1:0] c_OP_SRL  = 5'b00110;
  localparam logic [OP_W-1:0] c_OP_ROTR = 5'b00111;
  localparam logic [OP_W-1:0] c_OP_NOT  = 5'b01000;
  localparam logic [OP_W-1:0] c_OP_NAND = 5'b01001;
  localparam logic [OP_W-1:0] c_OP_MAX  = 5'b01010;
  localparam logic [OP_W-1:0] c_OP_MIN  = 5'b01011;
  localparam logic [OP_W-1:0] c_OP_ABS  = 5'b01100;
  localparam logic [OP_W-1:0] c_OP_SLTS = 5'b01101;
  localparam logic [OP_W-1:0] c_OP_SLL  = 5'b01110;
  localparam logic [OP_W-1:0] c_OP_ROTL = 5'b01111;
  localparam logic [OP_W-1:0] c_OP_ADDU = 5'b10000;
  localparam logic [OP_W-1:0] c_OP_SRLU = 5'b10001;
  localparam logic [OP_W-1:0] c_OP_MUL  = 5'b10010;
  localparam logic [OP_W-1:0] c_OP_MULU = 5'b10011;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_mul_serial.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_serial
//  Description : Shift-add multiplier, one multiplier bit per cycle, on operand
//                magnitudes; the sign is applied to the final sum.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_mul_serial
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                signed_mode,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic                done,
  output logic [2*DATA_W-1:0] prod
);

  localparam int CNT_W = $clog2(DATA_W);

  logic                busy_q,   busy_d;
  logic                neg_q,    neg_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [2*DATA_W-1:0] mcand_q,  mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [2*DATA_W-1:0] acc_q,    acc_d;

  logic [DATA_W-1:0]   w_a_mag;
  logic [DATA_W-1:0]   w_b_mag;
  logic [2*DATA_W-1:0] w_step_acc;

  // The most negative operand's magnitude still fits as an unsigned DATA_W value.
  always_comb begin
    w_a_mag    = (signed_mode && a[DATA_W-1]) ? -a : a;
    w_b_mag    = (signed_mode && b[DATA_W-1]) ? -b : b;
    w_step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);
    done       = busy_q && (cnt_q == CNT_W'(DATA_W-1));
    prod       = neg_q ? -w_step_acc : w_step_acc;
  end

  always_comb begin
    busy_d   = busy_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start) begin
      busy_d   = 1'b1;
      neg_d    = signed_mode && (a[DATA_W-1] ^ b[DATA_W-1]);
      cnt_d    = '0;
      mcand_d  = {{DATA_W{1'b0}}, w_a_mag};
      mplier_d = w_b_mag;
      acc_d    = '0;
    end else if (busy_q) begin
      acc_d    = w_step_acc;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (done) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Registered valid/ready ALU with single-cycle ops, serial
//                signed/unsigned multiply and a sticky overflow flag.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_out,
  output logic              alu_overflow,
  output logic              ovf_sticky,
  input  logic              ovf_clr
);

  localparam int SH_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] c_MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  state_e state_q, state_d;

  logic              out_valid_q,  out_valid_d;
  logic [DATA_W-1:0] alu_out_q,    alu_out_d;
  logic              alu_ovf_q,    alu_ovf_d;
  logic              ovf_sticky_q, ovf_sticky_d;
  logic              mul_signed_q, mul_signed_d;

  logic                w_accept;
  logic                w_is_mul;
  logic                w_mul_start;
  logic                w_mul_done;
  logic [2*DATA_W-1:0] w_mul_prod;
  logic [DATA_W-1:0]   w_mul_res;
  logic                w_mul_ovf;
  logic [DATA_W-1:0]   w_res;
  logic                w_ovf;
  logic [SH_W-1:0]     w_sh;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W-1:0]   w_diff;
  logic [2*DATA_W-1:0] w_rotr;
  logic [2*DATA_W-1:0] w_rotl;
  logic                w_lt;
  logic [DATA_W:0]     w_mul_hi;

  assign w_is_mul = (alu_op == c_OP_MUL) || (alu_op == c_OP_MULU);

  // ---------------- FSM: state register / next state / outputs ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_accept && w_is_mul) state_d = MUL;
      MUL:     if (w_mul_done)           state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A held result being drained this cycle frees the slot for a new accept.
  always_comb begin
    in_ready    = (state_q == IDLE) && (!out_valid_q || out_ready);
    w_accept    = in_valid && in_ready;
    w_mul_start = w_accept && w_is_mul;
  end

  // ---------------- single-cycle datapath ----------------
  always_comb begin
    w_sh   = src2[SH_W-1:0];
    w_sum  = {1'b0, src1} + {1'b0, src2};
    w_diff = src1 - src2;
    w_rotr = {src1, src1} >> w_sh;
    w_rotl = {src1, src1} << w_sh;
    w_lt   = $signed(src1) < $signed(src2);
    w_res  = '0;
    w_ovf  = 1'b0;
    case (alu_op)
      c_OP_ADD: begin
        w_res = w_sum[DATA_W-1:0];
        w_ovf = (src1[DATA_W-1] == src2[DATA_W-1]) && (w_sum[DATA_W-1] != src1[DATA_W-1]);
      end
      c_OP_SUB: begin
        w_res = w_diff;
        w_ovf = (src1[DATA_W-1] != src2[DATA_W-1]) && (w_diff[DATA_W-1] != src1[DATA_W-1]);
      end
      c_OP_AND:  w_res = src1 & src2;
      c_OP_OR:   w_res = src1 | src2;
      c_OP_XOR:  w_res = src1 ^ src2;
      c_OP_NOR:  w_res = ~(src1 | src2);
      c_OP_NOT:  w_res = ~src1;
      c_OP_NAND: w_res = ~(src1 & src2);
      c_OP_SRL:  w_res = $signed(src1) >>> w_sh;
      c_OP_SRLU: w_res = src1 >> w_sh;
      c_OP_SLL:  w_res = src1 << w_sh;
      c_OP_ROTR: w_res = w_rotr[DATA_W-1:0];
      c_OP_ROTL: w_res = w_rotl[2*DATA_W-1:DATA_W];
      c_OP_MAX:  w_res = ($signed(src1) > $signed(src2)) ? src1 : src2;
      c_OP_MIN:  w_res = w_lt ? src1 : src2;
      c_OP_ABS: begin
        w_res = src1[DATA_W-1] ? -src1 : src1;
        w_ovf = (src1 == c_MIN_NEG);
      end
      c_OP_SLTS: w_res = {{(DATA_W-1){1'b0}}, w_lt};
      c_OP_ADDU: begin
        w_res = w_sum[DATA_W-1:0];
        w_ovf = w_sum[DATA_W];
      end
      default: begin
        w_res = '0;
        w_ovf = 1'b0;
      end
    endcase
  end

  // ---------------- serial multiplier ----------------
  alu_mul_serial #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (w_mul_start),
    .signed_mode (alu_op == c_OP_MUL),
    .a           (src1),
    .b           (src2),
    .done        (w_mul_done),
    .prod        (w_mul_prod)
  );

  // Signed result fits only if the top DATA_W+1 product bits are a pure sign extension.
  always_comb begin
    w_mul_res = w_mul_prod[DATA_W-1:0];
    w_mul_hi  = w_mul_prod[2*DATA_W-1:DATA_W-1];
    if (mul_signed_q) begin
      w_mul_ovf = !((&w_mul_hi) || !(|w_mul_hi));
    end else begin
      w_mul_ovf = |w_mul_prod[2*DATA_W-1:DATA_W];
    end
  end

  // ---------------- result holding and sticky overflow ----------------
  always_comb begin
    out_valid_d  = out_valid_q;
    alu_out_d    = alu_out_q;
    alu_ovf_d    = alu_ovf_q;
    mul_signed_d = mul_signed_q;
    if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (w_accept && !w_is_mul) begin
      out_valid_d = 1'b1;
      alu_out_d   = w_res;
      alu_ovf_d   = w_ovf;
    end else if ((state_q == MUL) && w_mul_done) begin
      out_valid_d = 1'b1;
      alu_out_d   = w_mul_res;
      alu_ovf_d   = w_mul_ovf;
    end
    if (w_mul_start) begin
      mul_signed_d = (alu_op == c_OP_MUL);
    end
    ovf_sticky_d = ovf_sticky_q;
    if (out_valid_q && out_ready && alu_ovf_q) begin
      ovf_sticky_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      alu_out_q    <= '0;
      alu_ovf_q    <= 1'b0;
      ovf_sticky_q <= 1'b0;
      mul_signed_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      alu_out_q    <= alu_out_d;
      alu_ovf_q    <= alu_ovf_d;
      ovf_sticky_q <= ovf_sticky_d;
      mul_signed_q <= mul_signed_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign alu_out      = alu_out_q;
  assign alu_overflow = alu_ovf_q;
  assign ovf_sticky   = ovf_sticky_q;

endmodule
`default_nettype wire
